mips_multicycle_alu: RTL
========================

Name: mips_multicycle_alu

Overview:
- Execution-side consumer of the ALU select code produced by the ALU decoder.
- Executes one operation per transaction using a valid/ready handshake on both input and output.
- ADD and SUB complete in one cycle. SLL, SLLV and SRAV use an iterative 1-bit-per-cycle shifter.
- Used by the multi-cycle MIPS core. Its result feeds the register-file writeback path.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, $clog2(DATA_W) = 5, shift-amount width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- alu_sel  input  alu_sel_t  operation code, from MIPS_Generic_Definitions package.
- a  input  DATA_W  operand A (rs).
- b  input  DATA_W  operand B (rt or immediate).
- shamt  input  SHAMT_W  instruction shift-amount field.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  DATA_W  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB only).
- err  output  1  unsupported alu_sel was received.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0, err=0. Internal shift counter and shift register are cleared.
- Reset mid-operation: any operation in flight is discarded with no output. After reset deasserts, the block is in IDLE with in_ready=1.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. a, b, shamt and alu_sel are captured at that edge and are not sampled again.
- in_ready = (state==IDLE). This is a registered state decode with no combinational path from out_ready. Maximum throughput is one operation every two cycles.
- States: IDLE, SHIFT, DONE.
- IDLE, on accept:
  - ADD_ALU_Sel: result = a+b mod 2^DATA_W; overflow = (a[msb]==b[msb]) && (result[msb]!=a[msb]). Go to DONE.
  - SUB_ALU_Sel: result = a-b mod 2^DATA_W; overflow = (a[msb]!=b[msb]) && (result[msb]!=a[msb]). Go to DONE.
  - SLL_ALU_Sel: shift register = b, count = shamt.
  - SLLV_ALU_Sel: shift register = b, count = a[SHAMT_W-1:0], left logical.
  - SRAV_ALU_Sel: shift register = b, count = a[SHAMT_W-1:0], right arithmetic (msb replicated).
  - Shift with count==0: result = b, go directly to DONE. Otherwise go to SHIFT.
  - ERR_ALU_Sel or any other code: result=0, err=1. Go to DONE.
  - For all non-ADD/SUB operations, overflow=0.
- SHIFT: each cycle, shift by 1 and decrement count. When count reaches 1 on the current shift step, load result and go to DONE.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - ADD/SUB/ERR/zero-count shift: 1 cycle.
  - Shift by n>0: n+1 cycles.
  - Maximum: DATA_W cycles (n=31).
- DONE:
  - out_valid=1. result, zero, overflow and err are held stable until out_ready.
  - zero = (result==0), registered with result.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle. err and overflow are cleared next cycle; result keeps its last value.
  - out_ready held low: the block stalls indefinitely in DONE with outputs stable.
- Shift semantics: amounts above DATA_W-1 are impossible because SHAMT_W bits are used. Bits shifted out are lost. SRAV of a negative value saturates toward all ones. SLL by 31 leaves only the original b[0] in the msb.
- in_valid while busy (SHIFT/DONE) is ignored. The requester must hold the request until in_ready.
- Changes on alu_sel, a, b or shamt after accept do not affect the in-flight operation.

Test Plan:
- Reset then ADD a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept; result=0x80000000, overflow=1, zero=0, err=0.
- SUB a=5, b=5 -> result=0, zero=1, overflow=0. Then SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
- SLL b=0x00000003, shamt=4 -> out_valid exactly 5 cycles after accept, result=0x30. SLLV b=1, a=31 -> result=0x80000000 after 32 cycles. SLL with shamt=0 -> result=b after 1 cycle.
- SRAV b=0x80000000, a=0x24 (count=4) -> result=0xF8000000 after 5 cycles, in_ready=0 throughout. in_valid pulses during SHIFT are ignored and no extra result appears.
- Unsupported alu_sel (ERR_ALU_Sel) -> after 1 cycle result=0, err=1, zero=1. With out_ready held low for 10 cycles, outputs stay stable. After out_ready, err=0 and in_ready=1.
- Start SLLV with count=20, assert rst_n=0 asynchronously at cycle 7 -> out_valid=0 and in_ready=1 immediately. After release, ADD 2+3 -> result=5 in 1 cycle, with no residual output.

Source files
------------

// File: rtl/mips_multicycle_alu.sv
// Multi-cycle execution ALU for the MIPS core: single-cycle ADD/SUB plus an
// iterative one-bit-per-cycle shifter, with valid/ready on both sides.

package MIPS_Generic_Definitions;

   typedef enum logic [3:0] {
      ADD_ALU_Sel  = 4'd0,
      SUB_ALU_Sel  = 4'd1,
      SLL_ALU_Sel  = 4'd2,
      SLLV_ALU_Sel = 4'd3,
      SRAV_ALU_Sel = 4'd4,
      ERR_ALU_Sel  = 4'd15
   } alu_sel_t;

endpackage

module mips_multicycle_alu
   import MIPS_Generic_Definitions::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  alu_sel_t          alu_sel,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              overflow,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0]  shift_reg;
   logic [SHAMT_W-1:0] count;
   logic               shift_right;

   logic [DATA_W-1:0]  sum;
   logic [DATA_W-1:0]  diff;
   logic [DATA_W-1:0]  shift_step;
   logic               is_shift;
   logic [SHAMT_W-1:0] shift_amt;
   logic               accept;
   logic               last_step;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last_step = (count == SHAMT_W'(1));

   assign sum  = a + b;
   assign diff = a - b;

   // The right shift replicates the msb so SRAV of a negative value fills with ones.
   assign shift_step = shift_right ? {shift_reg[DATA_W-1], shift_reg[DATA_W-1:1]}
                                   : {shift_reg[DATA_W-2:0], 1'b0};

   always_comb begin
      is_shift  = 1'b0;
      shift_amt = '0;
      case (alu_sel)
         SLL_ALU_Sel: begin
            is_shift  = 1'b1;
            shift_amt = shamt;
         end
         SLLV_ALU_Sel, SRAV_ALU_Sel: begin
            is_shift  = 1'b1;
            shift_amt = a[SHAMT_W-1:0];
         end
         default: begin
            is_shift  = 1'b0;
            shift_amt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (is_shift && (shift_amt != '0)) begin
                  state_next = SHIFT;
               end else begin
                  state_next = DONE;
               end
            end
         end
         SHIFT: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operands are captured only at the accept edge; later input changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result      <= '0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         err         <= 1'b0;
         shift_reg   <= '0;
         count       <= '0;
         shift_right <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  overflow <= 1'b0;
                  err      <= 1'b0;
                  case (alu_sel)
                     ADD_ALU_Sel: begin
                        result   <= sum;
                        zero     <= (sum == '0);
                        overflow <= (a[DATA_W-1] == b[DATA_W-1]) &&
                                    (sum[DATA_W-1] != a[DATA_W-1]);
                     end
                     SUB_ALU_Sel: begin
                        result   <= diff;
                        zero     <= (diff == '0);
                        overflow <= (a[DATA_W-1] != b[DATA_W-1]) &&
                                    (diff[DATA_W-1] != a[DATA_W-1]);
                     end
                     SLL_ALU_Sel, SLLV_ALU_Sel, SRAV_ALU_Sel: begin
                        shift_reg   <= b;
                        count       <= shift_amt;
                        shift_right <= (alu_sel == SRAV_ALU_Sel);
                        if (shift_amt == '0) begin
                           result <= b;
                           zero   <= (b == '0);
                        end
                     end
                     default: begin
                        result <= '0;
                        zero   <= 1'b1;
                        err    <= 1'b1;
                     end
                  endcase
               end
            end
            SHIFT: begin
               shift_reg <= shift_step;
               count     <= count - SHAMT_W'(1);
               if (last_step) begin
                  result <= shift_step;
                  zero   <= (shift_step == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  err      <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            default: begin
               err      <= 1'b0;
               overflow <= 1'b0;
            end
         endcase
      end
   end

endmodule
